rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The block SHALL have parameter BitWidth, default 8, data width of every channel in bits.
REQ-002 The block SHALL have parameter N, default 8, number of input channels; legal range 2..64, need not be a power of two.
REQ-003 The block SHALL have parameter RoundRobin, default 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-004 The block SHALL have localparam SelWidth = $clog2(N).
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 d_i  input  unpacked array [N-1:0] of [BitWidth-1:0]  per-channel data.
REQ-008 valid_i  input  N  per-channel valid; bit k qualifies d_i[k].
REQ-009 ready_o  output  N  per-channel ready; bit k high = channel k beat accepted this cycle.
REQ-010 d_o  output  BitWidth  registered output data.
REQ-011 valid_o  output  1  registered output valid.
REQ-012 ready_i  input  1  downstream ready.
REQ-013 sel_o  output  SelWidth  index of channel whose beat is held in d_o.

Function
REQ-014 Transfer on any port SHALL occur only in a cycle where both valid and ready are high at the rising edge.
REQ-015 Output stage SHALL be a single registered slot; load_en = !valid_o | ready_i.
REQ-016 Grant g SHALL be combinational from valid_i and pointer ptr: RoundRobin=1 -> first k with valid_i[k] searching ptr, ptr+1, ... wrapping mod N; RoundRobin=0 -> lowest k with valid_i[k].
REQ-017 ready_o[k] SHALL be 1 iff load_en and any valid_i bit set and k == g; at most one ready_o bit high per cycle (one-hot or zero).
REQ-018 On accept of channel g: d_o <= d_i[g], sel_o <= g, valid_o <= 1, one cycle latency from accept to valid_o.
REQ-019 If load_en and no valid_i bit set: valid_o <= 0; d_o and sel_o SHALL hold their previous values.
REQ-020 If !load_en (valid_o & !ready_i): d_o, sel_o, valid_o SHALL hold; all ready_o bits 0 (backpressure).
REQ-021 Simultaneous drain and fill (valid_o & ready_i & accept) SHALL give back-to-back beats with no bubble: full throughput one beat per cycle.
REQ-022 ptr SHALL update only on accept: ptr <= (g == N-1) ? 0 : g+1; wrap SHALL be correct for non-power-of-two N (never reaches N).
REQ-023 With RoundRobin=0, ptr SHALL be unused and held at 0.
REQ-024 Round-robin fairness: with all N channels continuously valid and ready_i=1, each channel SHALL be granted exactly once per N consecutive accepts.
REQ-025 Input valid_i deassertion before acceptance SHALL be tolerated (no requirement that upstream holds valid); block SHALL not latch requests.
REQ-026 No X SHALL propagate to ready_o or valid_o when valid_i is all zero.

Reset
REQ-027 While rst_ni=0: valid_o=0, d_o='0, sel_o=0, ptr=0, ready_o=0, asynchronously and independent of clk_i.
REQ-028 Reset assertion mid-transfer SHALL discard the held beat; first accept after rst_ni rises SHALL be on the first rising edge with rst_ni=1 and arbitration from ptr=0.

Verification
REQ-029 Reset: rst_ni=0 with valid_i=all ones -> valid_o=0, ready_o=0, d_o=0, sel_o=0 immediately, no clock needed.
REQ-030 RR rotation (N=4, RoundRobin=1): valid_i=4'b1111, ready_i=1, d_i[k]=8'h10+k -> d_o sequence 10,11,12,13,10 with sel_o 0,1,2,3,0, valid_o high every cycle from cycle 1.
REQ-031 Backpressure: valid_o=1 holding 8'hA5, ready_i=0 for 5 cycles -> d_o stays A5, ready_o=0 each cycle; ready_i=1 -> next granted beat appears next cycle.
REQ-032 Skip/wrap (N=5, RoundRobin=1): ptr=4, valid_i=5'b00010 -> grant 1, ptr becomes 2; then valid_i=5'b10001 -> grant 4, ptr becomes 0.
REQ-033 Fixed priority (RoundRobin=0): valid_i=4'b1010 held, ready_i=1 -> channel 1 granted every cycle, channel 3 never; ready_o=4'b0010.
REQ-034 Reset mid-stream: beat 8'h3C held with ready_i=0, pulse rst_ni low -> valid_o=0; after release with valid_i=4'b0100 -> sel_o=2 one cycle after first post-reset edge.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N upstream channels and one registered downstream slot.
interface rr_arb_mux_if #(
    parameter int BitWidth = 8,
    parameter int N        = 8
);
    localparam int SelWidth = $clog2(N);

    logic [BitWidth-1:0] d_i [N-1:0];
    logic [N-1:0]        valid_i;
    logic [N-1:0]        ready_o;
    logic [BitWidth-1:0] d_o;
    logic                valid_o;
    logic                ready_i;
    logic [SelWidth-1:0] sel_o;

    modport slave (
        input  d_i, valid_i, ready_i,
        output ready_o, d_o, valid_o, sel_o
    );

    modport master (
        output d_i, valid_i, ready_i,
        input  ready_o, d_o, valid_o, sel_o
    );
endinterface

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrating mux with a single registered output slot.
// Round-robin (rotating pointer) or fixed lowest-index priority.
module rr_arb_mux #(
    parameter int BitWidth   = 8,
    parameter int N          = 8,
    parameter int RoundRobin = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    rr_arb_mux_if.slave  bus
);
    localparam int SelWidth = $clog2(N);

    logic [SelWidth-1:0] ptr;
    logic [SelWidth-1:0] grant;
    logic                any_valid;
    logic                load_en;
    logic                accept;

    logic [BitWidth-1:0] d_q;
    logic [SelWidth-1:0] sel_q;
    logic                valid_q;

    // Search from ptr, wrapping mod N; with ptr held at 0 this is fixed priority.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && bus.valid_i[idx]) begin
                grant = SelWidth'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_valid = |bus.valid_i;
    assign load_en   = !valid_q || bus.ready_i;
    // Gating with rst_ni keeps ready_o low for the whole reset, not just after an edge.
    assign accept    = rst_ni && load_en && any_valid;

    assign bus.ready_o = accept ? (N'(1) << grant) : '0;
    assign bus.d_o     = d_q;
    assign bus.sel_o   = sel_q;
    assign bus.valid_o = valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            d_q     <= bus.d_i[grant];
            sel_q   <= grant;
            valid_q <= 1'b1;
        end else if (load_en) begin
            valid_q <= 1'b0;
        end
    end

    generate
        if (RoundRobin != 0) begin : g_rr
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ptr <= '0;
                end else if (accept) begin
                    ptr <= (grant == SelWidth'(N - 1)) ? '0 : grant + 1'b1;
                end
            end
        end else begin : g_fixed
            assign ptr = '0;
        end
    endgenerate
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: round-robin N=4, round-robin N=5 (wrap) and fixed-priority N=4.
module tb_rr_arb_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux_if #(.BitWidth(8), .N(4)) bus_a ();
    rr_arb_mux_if #(.BitWidth(8), .N(5)) bus_b ();
    rr_arb_mux_if #(.BitWidth(8), .N(4)) bus_c ();

    rr_arb_mux #(.BitWidth(8), .N(4), .RoundRobin(1)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a));
    rr_arb_mux #(.BitWidth(8), .N(5), .RoundRobin(1)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b));
    rr_arb_mux #(.BitWidth(8), .N(4), .RoundRobin(0)) dut_c (.clk_i(clk), .rst_ni(rst_n), .bus(bus_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.valid_i = '0; bus_a.ready_i = 1'b1;
        bus_b.valid_i = '0; bus_b.ready_i = 1'b1;
        bus_c.valid_i = '0; bus_c.ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus_a.d_i[k] = 8'h10 + 8'(k);
            bus_c.d_i[k] = 8'h20 + 8'(k);
        end
        for (int k = 0; k < 5; k++) bus_b.d_i[k] = 8'h30 + 8'(k);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        tick();
        bus_a.valid_i = 4'b1111;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_a.valid_o !== 1'b0 || bus_a.ready_o !== 4'b0000 || bus_a.d_o !== 8'h00 || bus_a.sel_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_async: valid_o=%b ready_o=%b d_o=%h sel_o=%0d, want 0/0000/00/0",
                     bus_a.valid_o, bus_a.ready_o, bus_a.d_o, bus_a.sel_o);
        end
        rst_n = 1'b1;
        bus_a.valid_i = '0;
        #1;
    endtask

    task automatic test_rr_rotation();
        logic [7:0] exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        logic [1:0] exp_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus_a.valid_i = 4'b1111;
        bus_a.ready_i = 1'b1;
        #1;
        checks++;
        if (bus_a.ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL rr_first_grant: ready_o=%b want 0001", bus_a.ready_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus_a.valid_o !== 1'b1 || bus_a.d_o !== exp_d[i] || bus_a.sel_o !== exp_s[i]) begin
                errors++;
                $display("FAIL rr_rotation[%0d]: valid_o=%b d_o=%h sel_o=%0d want 1/%h/%0d",
                         i, bus_a.valid_o, bus_a.d_o, bus_a.sel_o, exp_d[i], exp_s[i]);
            end
        end
        bus_a.valid_i = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus_a.d_i[0]  = 8'hA5;
        bus_a.d_i[2]  = 8'h5A;
        bus_a.valid_i = 4'b0001;
        bus_a.ready_i = 1'b1;
        tick();
        bus_a.valid_i = 4'b0100;
        bus_a.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus_a.ready_o !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready[%0d]: ready_o=%b want 0000", i, bus_a.ready_o);
            end
            tick();
            checks++;
            if (bus_a.valid_o !== 1'b1 || bus_a.d_o !== 8'hA5 || bus_a.sel_o !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid_o=%b d_o=%h sel_o=%0d want 1/a5/0",
                         i, bus_a.valid_o, bus_a.d_o, bus_a.sel_o);
            end
        end
        bus_a.ready_i = 1'b1;
        #1;
        checks++;
        if (bus_a.ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_ready: ready_o=%b want 0100", bus_a.ready_o);
        end
        tick();
        checks++;
        if (bus_a.valid_o !== 1'b1 || bus_a.d_o !== 8'h5A || bus_a.sel_o !== 2'd2) begin
            errors++;
            $display("FAIL bp_release_beat: valid_o=%b d_o=%h sel_o=%0d want 1/5a/2",
                     bus_a.valid_o, bus_a.d_o, bus_a.sel_o);
        end
        bus_a.valid_i = '0;
        tick();
        checks++;
        if (bus_a.valid_o !== 1'b0 || bus_a.d_o !== 8'h5A || bus_a.sel_o !== 2'd2) begin
            errors++;
            $display("FAIL empty_hold: valid_o=%b d_o=%h sel_o=%0d want 0/5a/2",
                     bus_a.valid_o, bus_a.d_o, bus_a.sel_o);
        end
        bus_a.d_i[0] = 8'h10;
        bus_a.d_i[2] = 8'h12;
    endtask

    task automatic test_skip_wrap();
        logic [4:0] vin   [4] = '{5'b01000, 5'b00010, 5'b10001, 5'b10001};
        logic [4:0] exp_r [4] = '{5'b01000, 5'b00010, 5'b10000, 5'b00001};
        logic [2:0] exp_s [4] = '{3'd3, 3'd1, 3'd4, 3'd0};
        logic [2:0] fair  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        do_reset();
        bus_b.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_b.valid_i = vin[i];
            #1;
            checks++;
            if (bus_b.ready_o !== exp_r[i]) begin
                errors++;
                $display("FAIL wrap_ready[%0d]: ready_o=%b want %b", i, bus_b.ready_o, exp_r[i]);
            end
            tick();
            checks++;
            if (bus_b.valid_o !== 1'b1 || bus_b.sel_o !== exp_s[i] || bus_b.d_o !== 8'h30 + 8'(exp_s[i])) begin
                errors++;
                $display("FAIL wrap_beat[%0d]: valid_o=%b sel_o=%0d d_o=%h want 1/%0d",
                         i, bus_b.valid_o, bus_b.sel_o, bus_b.d_o, exp_s[i]);
            end
        end
        bus_b.valid_i = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus_b.sel_o !== fair[i] || bus_b.valid_o !== 1'b1) begin
                errors++;
                $display("FAIL fair5[%0d]: sel_o=%0d valid_o=%b want %0d/1", i, bus_b.sel_o, bus_b.valid_o, fair[i]);
            end
        end
        bus_b.valid_i = '0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        bus_c.valid_i = 4'b1010;
        bus_c.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus_c.ready_o !== 4'b0010) begin
                errors++;
                $display("FAIL fixed_ready[%0d]: ready_o=%b want 0010", i, bus_c.ready_o);
            end
            tick();
            checks++;
            if (bus_c.sel_o !== 2'd1 || bus_c.d_o !== 8'h21 || bus_c.valid_o !== 1'b1) begin
                errors++;
                $display("FAIL fixed_beat[%0d]: sel_o=%0d d_o=%h valid_o=%b want 1/21/1",
                         i, bus_c.sel_o, bus_c.d_o, bus_c.valid_o);
            end
        end
        bus_c.valid_i = '0;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus_a.d_i[2]  = 8'h3C;
        bus_a.valid_i = 4'b0100;
        bus_a.ready_i = 1'b1;
        tick();
        bus_a.valid_i = '0;
        bus_a.ready_i = 1'b0;
        tick();
        checks++;
        if (bus_a.valid_o !== 1'b1 || bus_a.d_o !== 8'h3C) begin
            errors++;
            $display("FAIL mid_held: valid_o=%b d_o=%h want 1/3c", bus_a.valid_o, bus_a.d_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_a.valid_o !== 1'b0 || bus_a.d_o !== 8'h00 || bus_a.sel_o !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: valid_o=%b d_o=%h sel_o=%0d want 0/00/0",
                     bus_a.valid_o, bus_a.d_o, bus_a.sel_o);
        end
        rst_n = 1'b1;
        bus_a.ready_i = 1'b1;
        bus_a.valid_i = 4'b1111;
        #1;
        checks++;
        if (bus_a.ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr_reset: ready_o=%b want 0001", bus_a.ready_o);
        end
        bus_a.valid_i = 4'b0100;
        tick();
        checks++;
        if (bus_a.valid_o !== 1'b1 || bus_a.sel_o !== 2'd2 || bus_a.d_o !== 8'h3C) begin
            errors++;
            $display("FAIL mid_first_beat: valid_o=%b sel_o=%0d d_o=%h want 1/2/3c",
                     bus_a.valid_o, bus_a.sel_o, bus_a.d_o);
        end
        bus_a.valid_i = '0;
        bus_a.d_i[2]  = 8'h12;
    endtask

    initial begin
        idle_all();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_rr_rotation();
        test_backpressure();
        test_skip_wrap();
        test_fixed_priority();
        test_reset_midstream();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
